// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory access sequencer.
package slc3_mem_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SW_W     = 10;
  localparam int unsigned SW_PAD_W = 6;
  localparam int unsigned CNT_W    = 4;

  localparam logic [DATA_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} mem_state_t;
  typedef enum logic {OP_RD, OP_WR} mem_op_t;

endpackage

// File: rtl/slc3_io_regs.sv
// Memory-mapped I/O: hex display register and switch/SRAM read-data select.
module slc3_io_regs
  import slc3_mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hex_ld,
  input  logic [DATA_W-1:0] i_hex_d,
  input  logic              i_sel_sw,
  input  logic [SW_W-1:0]   i_switches,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic [DATA_W-1:0] o_hex,
  output logic [DATA_W-1:0] o_rd_data_c
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hex <= '0;
    end else if (i_hex_ld) begin
      o_hex <= i_hex_d;
    end
  end

  assign o_rd_data_c = i_sel_sw ? {SW_PAD_W'(0), i_switches} : i_sram_q;

endmodule

// File: rtl/slc3_mem_ctrl.sv
// Sequences CPU read/write requests into SRAM transactions with wait states,
// returns a one-cycle Mem_R handshake and decodes one memory-mapped I/O address.
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [DATA_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_from_CPU,
  output logic [DATA_W-1:0] Data_to_CPU,
  output logic              Mem_R,
  output logic              Err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rden,
  output logic              sram_wren,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  input  logic [SW_W-1:0]   Switches,
  output logic [DATA_W-1:0] hex_digits
);

  mem_state_t        r_state, w_next;
  mem_op_t           r_op;
  logic              r_io;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              w_req, w_req_io, w_take;
  logic              w_rden_d, w_wren_d, w_err_d, w_mem_r_d, w_cap, w_hex_ld;
  logic [DATA_W-1:0] w_rd_data;

  assign w_req    = Mem_OE | Mem_WE;
  assign w_req_io = (ADDR == IO_ADDR);
  assign w_take   = (r_state == IDLE) && w_req;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // I/O accesses and zero-wait builds go straight from ACCESS to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = ACCESS;
      ACCESS:  w_next = (r_io || (WAIT_CYCLES == 0)) ? DONE : WAIT;
      WAIT:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes only ever lead into ACCESS.
  always_comb begin
    w_rden_d  = 1'b0;
    w_wren_d  = 1'b0;
    w_err_d   = 1'b0;
    w_cnt_d   = r_cnt;
    w_mem_r_d = (w_next == DONE);
    w_cap     = (w_next == DONE) && (r_op == OP_RD);
    w_hex_ld  = (r_state == ACCESS) && r_io && (r_op == OP_WR);
    if (w_take) begin
      w_rden_d = !Mem_WE && !w_req_io;
      w_wren_d = Mem_WE && !w_req_io;
      w_err_d  = Mem_OE && Mem_WE;
    end
    if (r_state == ACCESS) begin
      w_cnt_d = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    end else if ((r_state == WAIT) && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op         <= OP_RD;
      r_io         <= 1'b0;
      r_cnt        <= '0;
      sram_addr    <= '0;
      sram_rden    <= 1'b0;
      sram_wren    <= 1'b0;
      Data_to_SRAM <= '0;
      Data_to_CPU  <= '0;
      Mem_R        <= 1'b0;
      Err          <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      sram_rden <= w_rden_d;
      sram_wren <= w_wren_d;
      Mem_R     <= w_mem_r_d;
      Err       <= w_err_d;
      if (w_take) begin
        r_op      <= Mem_WE ? OP_WR : OP_RD;
        r_io      <= w_req_io;
        sram_addr <= ADDR[ADDR_W-1:0];
        if (Mem_WE) Data_to_SRAM <= Data_from_CPU;
      end
      if (w_cap) Data_to_CPU <= w_rd_data;
    end
  end

  slc3_io_regs u_io_regs (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_hex_ld    (w_hex_ld),
    .i_hex_d     (Data_to_SRAM),
    .i_sel_sw    (r_io),
    .i_switches  (Switches),
    .i_sram_q    (Data_from_SRAM),
    .o_hex       (hex_digits),
    .o_rd_data_c (w_rd_data)
  );

endmodule
